uart_tx_sched: RTL

Byte scheduler sitting in front of the 8-bit serial `transmitter`. It shares the transmitter between two requesters (processor debug port, status reporter) with packet-granular round-robin arbitration. It sequences the transmitter's `send`/`busy` handshake, holds `data` stable for the whole frame, and flags a transmitter that fails to start.

---
 rtl/uart_tx_sched_if.sv | 26 ++
 rtl/uart_tx_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter handshake bundle for uart_tx_sched.
// A requester byte transfers on the rising edge where reqN_valid & reqN_ready are both high;
// valid/data/last must hold until then and ready never depends on a future edge.
interface uart_tx_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_busy,
    input  req0_ready, req1_ready, tx_send, tx_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_busy,
    output req0_ready, req1_ready, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler for a serial transmitter: packet-granular round robin,
// send/busy sequencing with start timeout, post-frame gap and a completed-frame counter.
module uart_tx_sched #(
  parameter int unsigned GAP           = 0,
  parameter int unsigned START_TIMEOUT = 4,
  parameter logic [15:0] COUNT_INIT    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_sched_if.slave    bus,
  output logic              active_src,
  output logic              locked,
  output logic              err,
  output logic [15:0]       byte_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  localparam logic [3:0] TO_LAST  = 4'(START_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam bit         HAS_GAP  = (GAP != 0);

  state_t     state, state_nxt;
  logic [3:0] to_cnt, gap_cnt;
  logic       lock_src, rr_ptr, tx_send_q;
  logic [7:0] tx_data_q;
  logic       window, eligible, accept, frame_done, timeout;
  logic       sel, sel_valid, sel_last;
  logic [7:0] sel_data;

  // Source selection: an open packet owns the scheduler, otherwise round robin on contention.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (locked) begin
      sel       = lock_src;
      sel_valid = lock_src ? bus.req1_valid : bus.req0_valid;
    end else if (bus.req0_valid && bus.req1_valid) begin
      sel       = rr_ptr;
      sel_valid = 1'b1;
    end else if (bus.req1_valid) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end else begin
      sel       = 1'b0;
      sel_valid = bus.req0_valid;
    end
    sel_data = sel ? bus.req1_data : bus.req0_data;
    sel_last = sel ? bus.req1_last : bus.req0_last;
  end

  // The accept window also covers the cycle that ends a frame (or the last gap cycle),
  // so the next byte is taken on the same edge and back-to-back frames are 12 cycles apart.
  always_comb begin
    state_nxt  = state;
    window     = 1'b0;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: window = 1'b1;
      ST_ISSUE: begin
        if (bus.tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          frame_done = 1'b1;
          window     = !HAS_GAP;
          state_nxt  = HAS_GAP ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          window    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A still-busy transmitter (e.g. after our own reset) must never see tx_data change.
    eligible = window && !bus.tx_busy && !rst;
    accept   = eligible && sel_valid;
    if (accept) state_nxt = ST_ISSUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      active_src <= 1'b0;
      locked     <= 1'b0;
      lock_src   <= 1'b0;
      rr_ptr     <= 1'b0;
      err        <= 1'b0;
      to_cnt     <= 4'd0;
      gap_cnt    <= 4'd0;
      byte_count <= COUNT_INIT;
    end else begin
      err <= timeout;
      if (accept) begin
        tx_data_q  <= sel_data;
        active_src <= sel;
        tx_send_q  <= 1'b1;
        to_cnt     <= 4'd0;
        if (sel_last) begin
          locked <= 1'b0;
          rr_ptr <= ~sel;
        end else begin
          locked   <= 1'b1;
          lock_src <= sel;
        end
      end else if (state == ST_ISSUE) begin
        if (bus.tx_busy || timeout) tx_send_q <= 1'b0;
        else                        to_cnt    <= to_cnt + 4'd1;
      end
      if (frame_done) begin
        byte_count <= byte_count + 16'd1;
        gap_cnt    <= 4'd0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

  assign bus.req0_ready = eligible && !sel;
  assign bus.req1_ready = eligible && sel;
  assign bus.tx_send    = tx_send_q;
  assign bus.tx_data    = tx_data_q;
  assign state_dbg      = state;

endmodule
